smu_data_bus: RTL and testbench

Parametrised data-side interconnect between the RV32I core's load/store port and NSLV memory-mapped slaves: memory, timer, GPIO and UART by default. It decodes each access against per-slave base/mask windows and drives a one-hot chip select. It tracks slave ready with a timeout and returns read data or an error to the core. It also keeps a sticky record of the first faulting address for debug.

---
 rtl/smu_bus_pkg.sv | 35 +++
 rtl/smu_addr_decoder.sv | 30 +++
 rtl/smu_data_bus.sv | 157 +++++++++++++++
 tb/tb_smu_data_bus.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/smu_bus_pkg.sv
// Shared definitions for the data-side bus: FSM states, default slave windows, clog2 helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package smu_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // Default slave windows: slave 0 = memory, 1 = timer, 2 = GPIO, 3 = UART
    localparam logic [31:0] MEM_BASE   = 32'h1000_0000;
    localparam logic [31:0] MEM_MASK   = 32'hF000_0000;
    localparam logic [31:0] TIMER_BASE = 32'h8000_0000;
    localparam logic [31:0] TIMER_MASK = 32'hFFFF_F000;
    localparam logic [31:0] GPIO_BASE  = 32'h8000_1000;
    localparam logic [31:0] GPIO_MASK  = 32'hFFFF_F000;
    localparam logic [31:0] UART_BASE  = 32'h8000_2000;
    localparam logic [31:0] UART_MASK  = 32'hFFFF_F000;

    // Ceiling log2; clog2(1) = 0
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/smu_addr_decoder.sv
// Priority address decoder: one-hot hit vector over NSLV base/mask windows, lowest index wins.
// Latency: combinational.
// Backpressure: none.
// Ports: addr (in)  - byte address to decode
//        hit  (out) - one-hot slave hit, all zero on miss
//        miss (out) - no window matched
module smu_addr_decoder #(
    parameter int                     NSLV     = 4,
    parameter int                     AWIDTH   = 32,
    parameter logic [NSLV*AWIDTH-1:0] SLV_BASE = '0,
    parameter logic [NSLV*AWIDTH-1:0] SLV_MASK = '0
) (
    input  logic [AWIDTH-1:0] addr,
    output logic [NSLV-1:0]   hit,
    output logic              miss
);

    always_comb begin
        hit  = '0;
        miss = 1'b1;
        for (int k = 0; k < NSLV; k++) begin
            // miss still set means no lower-index slave has claimed the address
            if (miss && ((addr & SLV_MASK[k*AWIDTH +: AWIDTH]) == SLV_BASE[k*AWIDTH +: AWIDTH])) begin
                hit[k] = 1'b1;
                miss   = 1'b0;
            end
        end
    end

endmodule

// File: rtl/smu_data_bus.sv
// Data-side interconnect: core load/store port to NSLV memory-mapped slaves with timeout and error log.
// Latency: accept cycle 0, s_sel cycle 1, m_ready cycle 2 with zero-wait slave; +1 per slave wait cycle.
// Backpressure: core holds m_req until m_ready; slave stalls via s_ready, bounded by TIMEOUT (0 = unbounded).
// Ports: clk/reset; m_* core request/response; s_* slave select, latched request, strobes, rdata/ready;
//        err_clr/err_valid/err_addr sticky first-error log.
module smu_data_bus
    import smu_bus_pkg::*;
#(
    parameter int                     NSLV     = 4,
    parameter int                     DWIDTH   = 32,
    parameter int                     AWIDTH   = 32,
    parameter logic [NSLV*AWIDTH-1:0] SLV_BASE = {UART_BASE, GPIO_BASE, TIMER_BASE, MEM_BASE},
    parameter logic [NSLV*AWIDTH-1:0] SLV_MASK = {UART_MASK, GPIO_MASK, TIMER_MASK, MEM_MASK},
    parameter int                     TIMEOUT  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     m_req,
    input  logic                     m_we,
    input  logic [AWIDTH-1:0]        m_addr,
    input  logic [DWIDTH-1:0]        m_wdata,
    input  logic [DWIDTH/8-1:0]      m_wbe,
    output logic                     m_ready,
    output logic [DWIDTH-1:0]        m_rdata,
    output logic                     m_err,
    output logic [NSLV-1:0]          s_sel,
    output logic [AWIDTH-1:0]        s_addr,
    output logic [DWIDTH-1:0]        s_wdata,
    output logic [DWIDTH/8-1:0]      s_wbe,
    output logic                     s_we,
    output logic                     s_re,
    input  logic [NSLV*DWIDTH-1:0]   s_rdata,
    input  logic [NSLV-1:0]          s_ready,
    input  logic                     err_clr,
    output logic                     err_valid,
    output logic [AWIDTH-1:0]        err_addr
);

    localparam int CW = (TIMEOUT > 0) ? clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TMO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    state_t             state;
    logic [CW-1:0]      tmo_cnt;
    logic [NSLV-1:0]    dec_hit;
    logic               dec_miss;
    logic               sel_ready;
    logic               timeout_hit;
    logic [DWIDTH-1:0]  sel_rdata;
    logic               err_event;
    logic [AWIDTH-1:0]  err_event_addr;

    smu_addr_decoder #(
        .NSLV     (NSLV),
        .AWIDTH   (AWIDTH),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK)
    ) u_dec (
        .addr (m_addr),
        .hit  (dec_hit),
        .miss (dec_miss)
    );

    // Only the selected slave's ready and data matter
    assign sel_ready = |(s_ready & s_sel);

    always_comb begin
        sel_rdata = '0;
        for (int k = 0; k < NSLV; k++) begin
            if (s_sel[k]) begin
                sel_rdata = sel_rdata | s_rdata[k*DWIDTH +: DWIDTH];
            end
        end
    end

    assign timeout_hit = (TIMEOUT > 0) && (tmo_cnt == TMO_LAST);

    // An error completion is decided either at accept (decode miss) or in ACCESS (timeout, ready wins)
    always_comb begin
        err_event      = 1'b0;
        err_event_addr = s_addr;
        if (state == ST_IDLE && m_req && dec_miss) begin
            err_event      = 1'b1;
            err_event_addr = m_addr;
        end else if (state == ST_ACCESS && !sel_ready && timeout_hit) begin
            err_event = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            tmo_cnt   <= '0;
            s_sel     <= '0;
            s_we      <= 1'b0;
            s_re      <= 1'b0;
            s_addr    <= '0;
            s_wdata   <= '0;
            s_wbe     <= '0;
            m_ready   <= 1'b0;
            m_rdata   <= '0;
            m_err     <= 1'b0;
            err_valid <= 1'b0;
            err_addr  <= '0;
        end else begin
            m_ready <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (m_req) begin
                        s_addr  <= m_addr;
                        s_wdata <= m_wdata;
                        s_wbe   <= m_wbe;
                        if (dec_miss) begin
                            state   <= ST_RESP;
                            m_ready <= 1'b1;
                            m_err   <= 1'b1;
                            m_rdata <= '0;
                        end else begin
                            state   <= ST_ACCESS;
                            s_sel   <= dec_hit;
                            s_we    <= m_we;
                            s_re    <= ~m_we;
                            tmo_cnt <= '0;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (sel_ready || timeout_hit) begin
                        state   <= ST_RESP;
                        m_ready <= 1'b1;
                        m_err   <= ~sel_ready;
                        m_rdata <= (sel_ready && s_re) ? sel_rdata : '0;
                        s_sel   <= '0;
                        s_we    <= 1'b0;
                        s_re    <= 1'b0;
                    end else begin
                        tmo_cnt <= tmo_cnt + CW'(1);
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase

            // A new error outranks a coincident clear
            if (err_event && (!err_valid || err_clr)) begin
                err_valid <= 1'b1;
                err_addr  <= err_event_addr;
            end else if (err_clr) begin
                err_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_smu_data_bus.sv
// Self-checking bench for smu_data_bus: directed vector table, hand sequences, randomized model check.
// Latency: n/a.
// Backpressure: slave ready modelled per access with a programmable wait count.
module tb_smu_data_bus;

    localparam int NSLV = 4;
    localparam int TMO  = 16;

    logic              clk;
    logic              reset;
    logic              m_req;
    logic              m_we;
    logic [31:0]       m_addr;
    logic [31:0]       m_wdata;
    logic [3:0]        m_wbe;
    logic              m_ready;
    logic [31:0]       m_rdata;
    logic              m_err;
    logic [3:0]        s_sel;
    logic [31:0]       s_addr;
    logic [31:0]       s_wdata;
    logic [3:0]        s_wbe;
    logic              s_we;
    logic              s_re;
    logic [127:0]      s_rdata;
    logic [3:0]        s_ready;
    logic              err_clr;
    logic              err_valid;
    logic [31:0]       err_addr;

    smu_data_bus dut (
        .clk       (clk),
        .reset     (reset),
        .m_req     (m_req),
        .m_we      (m_we),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_wbe     (m_wbe),
        .m_ready   (m_ready),
        .m_rdata   (m_rdata),
        .m_err     (m_err),
        .s_sel     (s_sel),
        .s_addr    (s_addr),
        .s_wdata   (s_wdata),
        .s_wbe     (s_wbe),
        .s_we      (s_we),
        .s_re      (s_re),
        .s_rdata   (s_rdata),
        .s_ready   (s_ready),
        .err_clr   (err_clr),
        .err_valid (err_valid),
        .err_addr  (err_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave model: selected slave becomes ready once it has been selected for wait_cfg cycles
    logic [31:0] slv_data [NSLV];
    int          wait_cfg;
    int          sel_age;
    logic [3:0]  noise;
    logic        rand_noise;

    always @(posedge clk) sel_age <= (s_sel != 4'b0) ? sel_age + 1 : 0;

    always_comb begin
        s_rdata = '0;
        s_ready = '0;
        for (int k = 0; k < NSLV; k++) begin
            s_rdata[k*32 +: 32] = slv_data[k];
            s_ready[k] = s_sel[k] ? (sel_age >= wait_cfg) : noise[k];
        end
    end

    int n_checks;
    int n_fail;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        noise = rand_noise ? 4'($urandom) : 4'b0;
    endtask

    // One complete access; returns cycles from accept edge to m_ready sample
    task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] wbe, input int wait_c, input logic clr,
                             output int lat, output logic [31:0] rdata, output logic err,
                             output logic [3:0] sel_seen, output int sel_cnt, output logic hold_ok);
        logic done;
        done = 1'b0; lat = 0; rdata = '0; err = 1'b0; sel_seen = '0; sel_cnt = 0; hold_ok = 1'b1;
        m_req = 1'b1; m_we = we; m_addr = addr; m_wdata = wdata; m_wbe = wbe;
        err_clr = clr; wait_cfg = wait_c;
        for (int i = 0; i < 100; i++) begin
            tick();
            lat++;
            err_clr = 1'b0;
            if (s_sel != 4'b0) begin
                sel_cnt++;
                sel_seen = sel_seen | s_sel;
                if (s_we !== we || s_re !== !we || s_addr !== addr || s_wdata !== wdata || s_wbe !== wbe)
                    hold_ok = 1'b0;
            end
            if (m_ready) begin
                if (s_sel != 4'b0 || s_we || s_re) hold_ok = 1'b0;
                rdata = m_rdata;
                err   = m_err;
                done  = 1'b1;
                break;
            end
        end
        m_req = 1'b0;
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL access_hang: no m_ready within 100 cycles for addr %0h", addr);
        end
        tick();
        if (m_ready) hold_ok = 1'b0;
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wbe;
        int          wait_c;
        int          lat;
        logic [31:0] rdata;
        logic        err;
        logic [3:0]  sel;
        int          sel_cnt;
        logic        ev;
        logic [31:0] ea;
    } vec_t;

    vec_t vecs [12];

    // Reference: base/mask windows per slave, priority by index
    logic [31:0] ref_base [NSLV];
    logic [31:0] ref_mask [NSLV];

    function automatic int ref_slave(input logic [31:0] a);
        for (int k = 0; k < NSLV; k++)
            if ((a & ref_mask[k]) == ref_base[k]) return k;
        return -1;
    endfunction

    initial begin
        int          lat;
        logic [31:0] rd;
        logic        er;
        logic [3:0]  sel;
        int          scnt;
        logic        hok;
        int          mready_seen;
        logic        mev;
        logic [31:0] mea;

        n_checks = 0; n_fail = 0;
        reset = 1'b1; m_req = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0; m_wbe = '0;
        err_clr = 1'b0; wait_cfg = 0; noise = '0; rand_noise = 1'b0;
        slv_data[0] = 32'hDEAD_BEEF; slv_data[1] = 32'h1111_2222;
        slv_data[2] = 32'h3333_4444; slv_data[3] = 32'h5555_6666;
        ref_base[0] = 32'h1000_0000; ref_mask[0] = 32'hF000_0000;
        ref_base[1] = 32'h8000_0000; ref_mask[1] = 32'hFFFF_F000;
        ref_base[2] = 32'h8000_1000; ref_mask[2] = 32'hFFFF_F000;
        ref_base[3] = 32'h8000_2000; ref_mask[3] = 32'hFFFF_F000;

        //            we    addr          wdata         wbe   wait  lat rdata         err   sel     cnt ev    ea
        vecs[0]  = '{1'b0, 32'h1000_0004, 32'h0,        4'h0, 0,    2,  32'hDEAD_BEEF, 1'b0, 4'b0001, 1,  1'b0, 32'h0};
        vecs[1]  = '{1'b1, 32'h8000_1008, 32'h0000_00A5, 4'h1, 3,   5,  32'h0,        1'b0, 4'b0100, 4,  1'b0, 32'h0};
        vecs[2]  = '{1'b0, 32'h4000_0000, 32'h0,        4'h0, 0,    1,  32'h0,        1'b1, 4'b0000, 0,  1'b1, 32'h4000_0000};
        vecs[3]  = '{1'b0, 32'h8000_0000, 32'h0,        4'h0, 1000, 17, 32'h0,        1'b1, 4'b0010, 16, 1'b1, 32'h4000_0000};
        vecs[4]  = '{1'b0, 32'h8000_2FFC, 32'h0,        4'h0, 1,    3,  32'h5555_6666, 1'b0, 4'b1000, 2,  1'b1, 32'h4000_0000};
        vecs[5]  = '{1'b0, 32'h8000_1000, 32'h0,        4'h0, 0,    2,  32'h3333_4444, 1'b0, 4'b0100, 1,  1'b1, 32'h4000_0000};
        vecs[6]  = '{1'b0, 32'h1FFF_FFFC, 32'h0,        4'h0, 2,    4,  32'hDEAD_BEEF, 1'b0, 4'b0001, 3,  1'b1, 32'h4000_0000};
        vecs[7]  = '{1'b1, 32'h8000_0004, 32'h1234_5678, 4'hF, 0,   2,  32'h0,        1'b0, 4'b0010, 1,  1'b1, 32'h4000_0000};
        vecs[8]  = '{1'b0, 32'h8000_3000, 32'h0,        4'h0, 0,    1,  32'h0,        1'b1, 4'b0000, 0,  1'b1, 32'h4000_0000};
        vecs[9]  = '{1'b0, 32'h0FFF_FFFF, 32'h0,        4'h0, 0,    1,  32'h0,        1'b1, 4'b0000, 0,  1'b1, 32'h4000_0000};
        vecs[10] = '{1'b0, 32'h1000_0100, 32'h0,        4'h0, 15,   17, 32'hDEAD_BEEF, 1'b0, 4'b0001, 16, 1'b1, 32'h4000_0000};
        vecs[11] = '{1'b1, 32'h1000_0200, 32'hCAFE_0001, 4'h3, 16,  17, 32'h0,        1'b1, 4'b0001, 16, 1'b1, 32'h4000_0000};

        // Reset state
        repeat (2) tick();
        check("rst s_sel", s_sel, 4'b0);
        check("rst s_we_re", {s_we, s_re}, 2'b0);
        check("rst m_ready_err", {m_ready, m_err}, 2'b0);
        check("rst m_rdata", m_rdata, 32'h0);
        check("rst s_addr", s_addr, 32'h0);
        check("rst s_wdata_wbe", {s_wdata, s_wbe}, 36'h0);
        check("rst err_valid", err_valid, 1'b0);
        check("rst err_addr", err_addr, 32'h0);
        reset = 1'b0;
        tick();

        // Directed vector table
        for (int i = 0; i < 12; i++) begin
            do_access(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].wbe, vecs[i].wait_c, 1'b0,
                      lat, rd, er, sel, scnt, hok);
            check($sformatf("vec%0d latency", i), lat, vecs[i].lat);
            check($sformatf("vec%0d m_rdata", i), rd, vecs[i].rdata);
            check($sformatf("vec%0d m_err", i), er, vecs[i].err);
            check($sformatf("vec%0d s_sel", i), sel, vecs[i].sel);
            check($sformatf("vec%0d sel_cycles", i), scnt, vecs[i].sel_cnt);
            check($sformatf("vec%0d hold", i), hok, 1'b1);
            check($sformatf("vec%0d err_valid", i), err_valid, vecs[i].ev);
            check($sformatf("vec%0d err_addr", i), err_addr, vecs[i].ea);
        end

        // Clear the log, then a fresh error is recorded
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("clr err_valid", err_valid, 1'b0);
        do_access(1'b0, 32'h7000_0000, 32'h0, 4'h0, 0, 1'b0, lat, rd, er, sel, scnt, hok);
        check("after clr err_valid", err_valid, 1'b1);
        check("after clr err_addr", err_addr, 32'h7000_0000);

        // Clear coincident with a new error: the new error wins
        do_access(1'b0, 32'h5000_0000, 32'h0, 4'h0, 0, 1'b1, lat, rd, er, sel, scnt, hok);
        check("coinc m_err", er, 1'b1);
        check("coinc err_valid", err_valid, 1'b1);
        check("coinc err_addr", err_addr, 32'h5000_0000);
        do_access(1'b0, 32'h6000_0000, 32'h0, 4'h0, 0, 1'b0, lat, rd, er, sel, scnt, hok);
        check("sticky err_addr", err_addr, 32'h5000_0000);

        // Reset in the middle of an access
        m_req = 1'b1; m_we = 1'b0; m_addr = 32'h8000_0000; wait_cfg = 1000;
        tick();
        tick();
        check("pre-rst s_sel", s_sel, 4'b0010);
        check("pre-rst s_re", s_re, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check("midrst s_sel", s_sel, 4'b0);
        check("midrst s_re", s_re, 1'b0);
        check("midrst err_valid", err_valid, 1'b0);
        m_req = 1'b0;
        mready_seen = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (m_ready) mready_seen++;
        end
        reset = 1'b0;
        tick();
        if (m_ready) mready_seen++;
        check("midrst no m_ready", mready_seen, 0);
        do_access(1'b0, 32'h1000_0000, 32'h0, 4'h0, 0, 1'b0, lat, rd, er, sel, scnt, hok);
        check("post-rst latency", lat, 2);
        check("post-rst m_rdata", rd, 32'hDEAD_BEEF);
        check("post-rst m_err", er, 1'b0);
        check("post-rst err_addr", err_addr, 32'h0);

        // Randomized accesses against the reference model
        mev = 1'b0;
        mea = 32'h0;
        rand_noise = 1'b1;
        for (int t = 0; t < 150; t++) begin
            logic [31:0] a;
            logic        we;
            logic        clr;
            int          w;
            int          k;
            int          sl;
            int          exp_lat;
            logic        exp_err;
            logic [31:0] exp_rd;
            int          exp_cnt;

            for (int j = 0; j < NSLV; j++) slv_data[j] = $urandom;
            sl = $urandom_range(0, 4);
            if (sl < NSLV) a = ref_base[sl] | ($urandom & ~ref_mask[sl]);
            else           a = $urandom;
            we  = 1'($urandom);
            w   = $urandom_range(0, 20);
            clr = ($urandom_range(0, 7) == 0);

            k = ref_slave(a);
            if (k < 0) begin
                exp_lat = 1; exp_err = 1'b1; exp_rd = 32'h0; exp_cnt = 0;
            end else if (w < TMO) begin
                exp_lat = w + 2; exp_err = 1'b0; exp_rd = we ? 32'h0 : slv_data[k]; exp_cnt = w + 1;
            end else begin
                exp_lat = TMO + 1; exp_err = 1'b1; exp_rd = 32'h0; exp_cnt = TMO;
            end
            if (clr) mev = 1'b0;
            if (exp_err && !mev) begin
                mev = 1'b1;
                mea = a;
            end

            do_access(we, a, $urandom, 4'($urandom), w, clr, lat, rd, er, sel, scnt, hok);
            check($sformatf("rnd%0d latency", t), lat, exp_lat);
            check($sformatf("rnd%0d m_rdata", t), rd, exp_rd);
            check($sformatf("rnd%0d m_err", t), er, exp_err);
            check($sformatf("rnd%0d s_sel", t), sel, (k < 0) ? 4'b0 : 4'(1 << k));
            check($sformatf("rnd%0d sel_cycles", t), scnt, exp_cnt);
            check($sformatf("rnd%0d hold", t), hok, 1'b1);
            check($sformatf("rnd%0d err_valid", t), err_valid, mev);
            check($sformatf("rnd%0d err_addr", t), err_addr, mea);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
